// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (LSB first, idle high).
// Define UART_TX_PARITY_EN to insert a parity bit; PARITY_ODD selects its sense.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    iTXdata,
  input  logic                          iTXvalid,
  output logic                          oTXready,
  output logic                          tx,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoCnt
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int PW       = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ZERO  = {(PW + 1){1'b0}};
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_DIV < 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  function automatic logic par_bit(input logic [7:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;

  logic [2:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_tx;
  logic          r_busy;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic          w_wr;
  logic          w_pop;
  logic          w_last;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_sh_nxt;
  logic          w_tx_nxt;

  // A full FIFO refuses writes even if a pop lands in the same cycle.
  assign oTXready = (r_cnt != CNT_FULL);
  assign w_wr     = iTXvalid && oTXready;
  assign w_last   = (r_baud == BAUD_LAST);
  assign oFifoCnt = r_cnt;
  assign tx       = r_tx;
  assign oBusy    = r_busy;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= iTXdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
      r_cnt  <= CNT_ZERO;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The baud counter restarts on every state entry and on every data-bit boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_ONE;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = BAUD_ZERO;
        if (r_cnt != CNT_ZERO) begin
          w_pop       = 1'b1;
          w_sh_nxt    = r_mem[r_rptr];
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = BAUD_ZERO;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_sh_nxt   = {1'b0, r_sh[7:1]};
          w_baud_nxt = BAUD_ZERO;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_AFTER_DATA;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_last) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = BAUD_ZERO;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (w_last) begin
          w_baud_nxt = BAUD_ZERO;
          if (r_cnt != CNT_ZERO) begin
            w_pop       = 1'b1;
            w_sh_nxt    = r_mem[r_rptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = BAUD_ZERO;
      end
    endcase
  end

  // Line level is decoded from the next state so tx is a plain flop.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_tx_nxt = 1'b1;
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      S_STOP:   w_tx_nxt = 1'b1;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= BAUD_ZERO;
      r_bit   <= 3'd0;
      r_sh    <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the whole byte at pop time, before any shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= par_bit(r_mem[r_rptr]);
    end else begin
      r_par <= r_par;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a line monitor decodes frames on tx and
// compares each byte against the queue filled by the stimulus.
module tb_uart_tx_fifo;

  localparam int DIV  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBIT = 11;
`else
  localparam int NBIT = 10;
`endif
  localparam int FRAME = NBIT * DIV;
  localparam int PODD  = 0;

  logic       clk;
  logic       rst_n;
  logic [7:0] iTXdata;
  logic       iTXvalid;
  logic       oTXready;
  logic       tx;
  logic       oBusy;
  logic [2:0] oFifoCnt;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit mon_en = 1'b1;
  logic [7:0] sb [$];
  int starts [$];

  uart_tx_fifo #(
    .CLK_FREQ  (DIV * 10),
    .BAUD      (10),
    .FIFO_DEPTH(4),
    .PARITY_ODD(PODD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iTXdata (iTXdata),
    .iTXvalid(iTXvalid),
    .oTXready(oTXready),
    .tx      (tx),
    .oBusy   (oBusy),
    .oFifoCnt(oFifoCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives n consecutive writes from a negedge; the first push_n bytes are expected on the line.
  task automatic burst(input logic [7:0] d [8], input int n, input int push_n);
    for (int i = 0; i < n; i++) begin
      if (i < push_n) sb.push_back(d[i]);
      iTXdata  = d[i];
      iTXvalid = 1'b1;
      @(negedge clk);
    end
    iTXvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((oBusy || oFifoCnt != 3'd0 || sb.size() != 0) && n < 20 * FRAME) begin
      n++;
      @(negedge clk);
    end
    chk("wait_idle_timeout", (n < 20 * FRAME) ? 32'd1 : 32'd0, 32'd1);
  endtask

  logic [7:0] mon_rx;
  logic [7:0] mon_exp;
  logic       mon_par;

  initial begin : monitor
    mon_par = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        chk("start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_rx[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        mon_par = tx;
`endif
        repeat (DIV) @(negedge clk);
        chk("stop_bit", tx, 1'b1);
        if (sb.size() == 0) begin
          chk("unexpected_frame", mon_rx, 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb.pop_front();
          chk("rx_byte", mon_rx, mon_exp);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", mon_par, (^mon_exp) ^ 1'(PODD));
`endif
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] d [8];
    int n;
    int lows;

    rst_n    = 1'b0;
    iTXdata  = 8'h00;
    iTXvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_ready", oTXready, 1'b1);
    chk("rst_cnt", oFifoCnt, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: latency, frame length, content.
    d = '{8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(d, 1, 1);
    chk("lat_tx_before", tx, 1'b1);
    chk("lat_cnt", oFifoCnt, 3'd1);
    @(negedge clk);
    chk("lat_tx_start", tx, 1'b0);
    chk("lat_busy", oBusy, 1'b1);
    n = 0;
    while (oBusy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, FRAME);
    chk("tx_idle_after", tx, 1'b1);
    wait_idle();

    // Three back-to-back bytes: no gap between frames.
    starts.delete();
    d = '{8'h34, 8'h38, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(d, 3, 3);
    wait_idle();
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", starts[1] - starts[0], FRAME);
      chk("b2b_gap2", starts[2] - starts[1], FRAME);
    end

    // Overfill: five writes fill the FIFO, the sixth is dropped.
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back(d[i]);
      iTXdata  = d[i];
      iTXvalid = 1'b1;
      @(negedge clk);
      if (i == 0) chk("fill_cnt1", oFifoCnt, 3'd1);
      if (i == 4) begin
        chk("full_cnt", oFifoCnt, 3'd4);
        chk("full_ready", oTXready, 1'b0);
      end
    end
    iTXvalid = 1'b0;
    chk("drop_cnt", oFifoCnt, 3'd4);
    wait_idle();
    repeat (2 * FRAME) @(negedge clk);
    chk("drop_no_tx", oBusy, 1'b0);

    // Write and pop in the same cycle at count 2.
    d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(d, 3, 3);
    repeat (FRAME - 2) @(negedge clk);
    chk("wp_cnt_before", oFifoCnt, 3'd2);
    sb.push_back(8'hC4);
    iTXdata  = 8'hC4;
    iTXvalid = 1'b1;
    @(negedge clk);
    iTXvalid = 1'b0;
    chk("wp_cnt_after", oFifoCnt, 3'd2);
    chk("wp_no_gap", tx, 1'b0);
    wait_idle();

    // Reset mid-frame, three data bits in.
    mon_en = 1'b0;
    d = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(d, 2, 0);
    repeat (DIV + 3 * DIV + 6) @(negedge clk);
    chk("mid_tx_bit3", tx, 1'b0);
    chk("mid_cnt", oFifoCnt, 3'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_busy", oBusy, 1'b0);
    chk("arst_cnt", oFifoCnt, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || oBusy !== 1'b0) lows++;
    end
    chk("post_rst_quiet", lows, 0);
    mon_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
